mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low: clk and rst_n.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: the maximum number of cycles spent in ACCESS while waiting for mem_ack.
REQ-003 Ports SHALL be:
  clk         in   1   rising-edge clock
  rst_n       in   1   synchronous reset, active low
  cpu_rd      in   1   CPU load request (the CPU's mem_read)
  cpu_wr      in   1   CPU store request (the CPU's mem_wrt)
  cpu_addr    in   32  byte address (the CPU's addr_bus)
  cpu_wdata   in   32  store data (the CPU's data_bus_out)
  cpu_rdata   out  32  load data, driven into the CPU's data_bus_in
  cpu_stall   out  1   freezes the CPU while an access is outstanding
  cpu_err     out  1   one-cycle pulse on a misaligned, conflicting or timed-out access
  mem_req     out  1   memory request, held until acknowledged
  mem_we      out  1   1 = write, 0 = read
  mem_addr    out  32  word-aligned address sent to memory
  mem_wdata   out  32  write data sent to memory
  mem_ack     in   1   memory completion, one-cycle pulse
  mem_rdata   in   32  read data, valid in the cycle mem_ack is high

Function
REQ-004 The FSM SHALL have four states: IDLE, ACCESS, HOLD and ERROR.
REQ-005 In IDLE, a legal request SHALL cause these actions at the next edge:
  - capture cpu_addr, cpu_wdata and mem_we=cpu_wr;
  - set mem_req=1;
  - go to ACCESS.
  A legal request is exactly one of cpu_rd/cpu_wr high, with cpu_addr[1:0]==0.
REQ-006 In IDLE, an illegal request SHALL set cpu_err=1 at the next edge, with no memory access, and go to ERROR. Illegal means both cpu_rd and cpu_wr high, or a misaligned address.
REQ-007 cpu_stall SHALL be combinational: high in IDLE when a legal request is present, and high throughout ACCESS; low otherwise.
REQ-008 In ACCESS, mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until mem_ack is sampled high.
REQ-009 On mem_ack in ACCESS, the block SHALL drop mem_req, go to HOLD, and register mem_rdata into cpu_rdata (for reads only).
REQ-010 cpu_rdata SHALL hold its value until the next completed read.
REQ-011 Minimum latency SHALL be as follows:
  - request seen in cycle 0;
  - mem_req high in cycle 1;
  - mem_ack in cycle 1 gives HOLD in cycle 2, with the stall released and data valid.
REQ-012 HOLD SHALL last exactly one cycle and then go to IDLE. CPU requests sampled in HOLD SHALL be ignored; they belong to the instruction that just completed.
REQ-013 A cycle counter SHALL clear on entry to ACCESS and increment each cycle in ACCESS.
REQ-014 If the counter reaches TIMEOUT_CYCLES without mem_ack, the block SHALL drop mem_req, pulse cpu_err, and go to ERROR.
REQ-015 mem_ack arriving on the same edge as the timeout SHALL take priority, giving a normal completion.
REQ-016 ERROR SHALL last one cycle with cpu_stall=0, then go to IDLE. cpu_err SHALL be high only during the ERROR cycle.
REQ-017 mem_ack received outside ACCESS SHALL be ignored.
REQ-018 Counter width SHALL be clog2(TIMEOUT_CYCLES+1), and it SHALL saturate, never wrap.

Reset
REQ-019 While rst_n is low at a clk edge, the block SHALL reset to:
  - state=IDLE and counter=0;
  - mem_req=0 and mem_we=0;
  - mem_addr, mem_wdata and cpu_rdata = 0;
  - cpu_err=0.
REQ-020 A reset asserted during ACCESS SHALL abandon the access: mem_req is low after that edge, and no cpu_err is raised.
REQ-021 cpu_stall SHALL be low throughout reset.

Structure
REQ-022 A shared header mem_bus_defs SHALL hold:
  - the state encodings (IDLE=0, ACCESS=1, HOLD=2, ERROR=3);
  - the alignment mask 2'b00;
  - the default TIMEOUT_CYCLES.
REQ-023 The timeout counter SHALL be a single sub-module, bus_timeout_cnt, with ports clk, rst_n, clr, en, expired.
REQ-024 The FSM and datapath registers SHALL stay in mem_bus_ctrl. There SHALL be no other sub-modules.

Verification
REQ-025 Read, ack after 3 cycles: cpu_rd=1, cpu_addr=0x100; memory returns mem_rdata=0xDEADBEEF. Required response:
  - mem_req high for cycles 1-3 with mem_addr=0x100 and mem_we=0;
  - stall high for cycles 0-3;
  - cycle 4: cpu_rdata=0xDEADBEEF and stall=0.
REQ-026 Write, ack in cycle 1: cpu_wr=1, addr=0x4, wdata=0x12345678. Required response:
  - mem_we=1, mem_wdata=0x12345678;
  - HOLD in cycle 2;
  - cpu_rdata unchanged.
REQ-027 Misaligned and conflicting requests (addr=0x102 read; then rd=wr=1 at 0x200). Required response for each: mem_req never asserted, cpu_err pulses for exactly 1 cycle, stall low.
REQ-028 Timeout: TIMEOUT_CYCLES=4, no ack. Required response:
  - mem_req drops after 4 ACCESS cycles;
  - cpu_err pulses once;
  - a late mem_ack is ignored;
  - the next request proceeds normally.
REQ-029 Reset mid-ACCESS: rst_n=0 in the 2nd ACCESS cycle. Required response: mem_req=0, all outputs 0 the next cycle, no cpu_err; a mem_ack pulsed the next cycle has no effect.

Source files
------------

// File: rtl/mem_bus_defs.sv
// Shared definitions for the CPU-to-memory bus controller: state encodings,
// the word-alignment mask and the default access timeout.
package mem_bus_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  localparam logic [1:0] ALIGN_MASK             = 2'b00;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating cycle counter that flags the last permitted ACCESS cycle.
module bus_timeout_cnt
  import mem_bus_defs::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry is raised during the TIMEOUT_CYCLES-th cycle spent counting.
  assign expired = en && (cnt_q >= CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bridges single-cycle CPU load/store requests onto a req/ack memory bus,
// stalling the CPU for the duration and flagging illegal or timed-out accesses.
module mem_bus_ctrl
  import mem_bus_defs::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_err_q, cpu_err_d;
  logic        legal_s, any_req_s, expired_s, cnt_clr_s, cnt_en_s;

  assign any_req_s = cpu_rd | cpu_wr;
  assign legal_s   = (cpu_rd ^ cpu_wr) && (cpu_addr[1:0] == ALIGN_MASK);
  assign cnt_clr_s = (state_q == ST_IDLE) && legal_s;
  assign cnt_en_s  = (state_q == ST_ACCESS);

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .expired(expired_s)
  );

  // Stall is gated by reset so a CPU held in reset is never frozen.
  assign cpu_stall = rst_n && (cnt_clr_s || (state_q == ST_ACCESS));

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (legal_s) begin
          state_d     = ST_ACCESS;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_wr;
          mem_addr_d  = {cpu_addr[31:2], 2'b00};
          mem_wdata_d = cpu_wdata;
        end else if (any_req_s) begin
          state_d   = ST_ERROR;
          cpu_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // A completion on the expiry edge wins over the timeout.
        if (mem_ack) begin
          state_d   = ST_HOLD;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            cpu_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end else if (expired_s) begin
          state_d   = ST_ERROR;
          mem_req_d = 1'b0;
          cpu_err_d = 1'b1;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_HOLD:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      cpu_rdata_q <= 32'h0000_0000;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: each stimulus cycle queues its expected
// output snapshot, and a negedge monitor pops and compares it.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0, mem_ack = 1'b0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0, mem_rdata = 32'h0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, cpu_err, mem_req, mem_we;

  typedef struct {
    int          cyc;
    string       nm;
    logic [3:0]  fl;   // {mem_req, mem_we, cpu_stall, cpu_err}
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] r;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .cpu_err  (cpu_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic rstn, input logic rd, input logic wr, input logic ack,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mrd,
                      input logic [3:0] e_fl, input logic [31:0] e_a, input logic [31:0] e_w,
                      input logic [31:0] e_r, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstn; cpu_rd = rd; cpu_wr = wr; mem_ack = ack;
    cpu_addr = addr; cpu_wdata = wdata; mem_rdata = mrd;
    e.cyc = cyc; e.nm = nm; e.fl = e_fl; e.a = e_a; e.w = e_w; e.r = e_r;
    sb_q.push_back(e);
  endtask

  // Monitor: compare the head snapshot against the DUT in its own cycle.
  initial begin
    exp_t       e;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        act = {mem_req, mem_we, cpu_stall, cpu_err};
        checks++;
        if (e.cyc != cyc || act !== e.fl || mem_addr !== e.a ||
            mem_wdata !== e.w || cpu_rdata !== e.r) begin
          failures++;
          $display("FAIL %s cyc=%0d got req/we/stall/err=%b addr=%h wdata=%h rdata=%h required %b addr=%h wdata=%h rdata=%h",
                   e.nm, cyc, act, mem_addr, mem_wdata, cpu_rdata, e.fl, e.a, e.w, e.r);
        end
      end
    end
  end

  initial begin
    // Reset and idle
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, "rst0");
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, "rst1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, "idle");
    // Read at 0x100, ack in third ACCESS cycle
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'b0010, 32'h0, 32'h0, 32'h0, "rd_c0");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'b1010, 32'h100, 32'h0, 32'h0, "rd_c1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'b1010, 32'h100, 32'h0, 32'h0, "rd_c2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 4'b1010, 32'h100, 32'h0, 32'h0, "rd_c3");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'b0000, 32'h100, 32'h0, 32'hDEADBEEF, "rd_hold");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0BAD0BAD, 4'b0000, 32'h100, 32'h0, 32'hDEADBEEF, "rd_idle_ack");
    // Write at 0x4, ack in first ACCESS cycle
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h12345678, 32'h0, 4'b0010, 32'h100, 32'h0, 32'hDEADBEEF, "wr_c0");
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 32'h12345678, 32'h55555555, 4'b1110, 32'h4, 32'h12345678, 32'hDEADBEEF, "wr_c1");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h12345678, 32'h0, 4'b0100, 32'h4, 32'h12345678, 32'hDEADBEEF, "wr_hold");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0100, 32'h4, 32'h12345678, 32'hDEADBEEF, "wr_idle");
    // Misaligned read, then conflicting rd+wr
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 32'h0, 4'b0100, 32'h4, 32'h12345678, 32'hDEADBEEF, "mis_c0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0101, 32'h4, 32'h12345678, 32'hDEADBEEF, "mis_err");
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 4'b0100, 32'h4, 32'h12345678, 32'hDEADBEEF, "conf_c0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0101, 32'h4, 32'h12345678, 32'hDEADBEEF, "conf_err");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0100, 32'h4, 32'h12345678, 32'hDEADBEEF, "conf_idle");
    // Timeout after four ACCESS cycles, late ack ignored
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 4'b0110, 32'h4, 32'h12345678, 32'hDEADBEEF, "to_c0");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 4'b1010, 32'h300, 32'h0, 32'hDEADBEEF, "to_acc");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFFFFFF, 4'b0001, 32'h300, 32'h0, 32'hDEADBEEF, "to_err_lateack");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 4'b0010, 32'h300, 32'h0, 32'hDEADBEEF, "after_to_c0");
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 32'hCAFEF00D, 4'b1010, 32'h8, 32'h0, 32'hDEADBEEF, "after_to_acc");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h8, 32'h0, 32'hCAFEF00D, "after_to_hold");
    // Ack on the same edge as expiry completes normally
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 4'b0010, 32'h8, 32'h0, 32'hCAFEF00D, "edge_c0");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 4'b1010, 32'hC, 32'h0, 32'hCAFEF00D, "edge_acc");
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'hC, 32'h0, 32'h13579BDF, 4'b1010, 32'hC, 32'h0, 32'hCAFEF00D, "edge_acc_ack");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'hC, 32'h0, 32'h13579BDF, "edge_hold");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'hC, 32'h0, 32'h13579BDF, "edge_idle");
    // Reset in the second ACCESS cycle of a write
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 32'h0, 4'b0010, 32'hC, 32'h0, 32'h13579BDF, "rstacc_c0");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 32'h0, 4'b1110, 32'h10, 32'hA5A5A5A5, 32'h13579BDF, "rstacc_c1");
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 32'h0, 4'b1100, 32'h10, 32'hA5A5A5A5, 32'h13579BDF, "rstacc_rst");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h77777777, 4'b0000, 32'h0, 32'h0, 32'h0, "rstacc_after");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, "rstacc_idle");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
